// File: rtl/bidir_shift_deserializer.sv
// rtl/bidir_shift_deserializer.sv - serial-to-parallel receiver with per-word MSB/LSB-first direction
// and a valid/ready holding register.
module bidir_shift_deserializer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             left,
  input  logic             right,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             out_ready,
  output logic [WIDTH-1:0] outbit,
  output logic             out_valid,
  output logic             overrun,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] count;
  logic             dir_msb;

  logic             accept;
  logic             use_msb;
  logic             complete;
  logic             hold_free;
  logic [WIDTH-1:0] next_sreg;

  // Direction is only taken from left/right on a word's first bit; left wins a tie.
  always_comb begin
    accept  = 1'b0;
    use_msb = dir_msb;
    if (state == IDLE) begin
      accept  = in_valid && (left || right);
      use_msb = left;
    end else begin
      accept  = in_valid;
    end
  end

  always_comb begin
    next_sreg = sreg;
    if (use_msb) begin
      next_sreg = {sreg[WIDTH-2:0], in_bit};
    end else begin
      next_sreg = {in_bit, sreg[WIDTH-1:1]};
    end
  end

  assign complete  = accept && (count == CNT_W'(WIDTH - 1));
  assign hold_free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state     <= IDLE;
      sreg      <= '0;
      count     <= '0;
      dir_msb   <= 1'b0;
      outbit    <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (accept) begin
        if (state == IDLE) begin
          dir_msb <= left;
        end
        if (complete) begin
          // Shifter restarts whether or not the finished word fits in the holding register.
          state <= IDLE;
          sreg  <= '0;
          count <= '0;
          busy  <= 1'b0;
          if (hold_free) begin
            outbit    <= next_sreg;
            out_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          state <= SHIFT;
          sreg  <= next_sreg;
          count <= count + CNT_W'(1);
          busy  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bidir_shift_deserializer.sv
// tb/tb_bidir_shift_deserializer.sv - scoreboard bench: directed scenarios then random traffic
// against a word-level reference model.
module tb_bidir_shift_deserializer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         left = 1'b0;
  logic         right = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_bit = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] outbit;
  logic         out_valid;
  logic         overrun;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: bits of the word in progress (arrival order), its direction,
  // whether the holding register is occupied, and whether an overrun pulse is due.
  int           bits_q[$];
  bit           m_msb = 1'b0;
  bit           m_full = 1'b0;
  bit           m_ovr = 1'b0;
  logic [W-1:0] exp_q[$];

  bidir_shift_deserializer #(.WIDTH(W), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .left(left), .right(right), .clear(clear),
    .in_valid(in_valid), .in_bit(in_bit), .out_ready(out_ready),
    .outbit(outbit), .out_valid(out_valid), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] assemble(input bit msb);
    int v = 0;
    for (int i = 0; i < W; i++) begin
      if (msb) v = v * 2 + bits_q[i];
      else     v = v + (bits_q[i] << i);
    end
    return W'(v);
  endfunction

  // Drive one cycle of inputs, predict the effect of the coming edge, then check after it.
  task automatic step(input logic iv, input logic b, input logic l, input logic r,
                      input logic rdy, input logic clr, input logic rs);
    bit was_full;
    in_valid = iv; in_bit = b; left = l; right = r;
    out_ready = rdy; clear = clr; rst_n = rs;
    if (!rs || clr) begin
      bits_q.delete();
      m_full = 1'b0;
      m_ovr  = 1'b0;
      exp_q.delete();
    end else begin
      m_ovr    = 1'b0;
      was_full = m_full;
      if (m_full && rdy) m_full = 1'b0;
      if (iv) begin
        if (bits_q.size() == 0) begin
          if (l || r) begin
            m_msb = l;
            bits_q.push_back(int'(b));
          end
        end else begin
          bits_q.push_back(int'(b));
        end
        if (bits_q.size() == W) begin
          if (!was_full || rdy) begin
            exp_q.push_back(assemble(m_msb));
            m_full = 1'b1;
          end else begin
            m_ovr = 1'b1;
          end
          bits_q.delete();
        end
      end
    end
    @(posedge clk);
    #1;
    check1("out_valid", out_valid, m_full);
    check1("busy", busy, bits_q.size() != 0);
    check1("overrun", overrun, m_ovr);
  endtask

  // Time-ordered bits: t[W-1] is sent first; ready may differ on the final bit.
  task automatic send(input logic [W-1:0] t, input logic l, input logic r,
                      input logic rdy, input logic rdy_last);
    for (int i = W - 1; i >= 0; i--) begin
      step(1'b1, t[i], l, r, (i == 0) ? rdy_last : rdy, 1'b0, 1'b1);
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, rdy, 1'b0, 1'b1);
  endtask

  // Monitor: a transfer happens at the next edge whenever valid and ready meet without flush.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && clear === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL outbit_unexpected: got %b with nothing expected at %0t", outbit, $time);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (outbit !== e) begin
          miscompares++;
          $display("FAIL outbit: got %b expected %b at %0t", outbit, e, $time);
        end
      end
    end
  end

  initial begin
    @(posedge clk); #1;
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (outbit !== '0) begin
      miscompares++;
      $display("FAIL reset_outbit: got %b expected 0000", outbit);
    end

    send(4'b1011, 1, 0, 0, 0);        // MSB-first -> 1011
    idle(1, 1);
    send(4'b1011, 0, 1, 1, 1);        // LSB-first -> 1101
    idle(1, 1);
    send(4'b1000, 1, 1, 1, 1);        // tie -> MSB-first 1000
    idle(1, 1);

    step(1, 0, 1, 0, 1, 0, 1);        // gaps and mid-word direction change -> 0110
    idle(3, 1);
    step(1, 1, 1, 0, 1, 0, 1);
    idle(3, 1);
    step(1, 1, 0, 1, 1, 0, 1);
    step(1, 0, 0, 1, 1, 0, 1);
    idle(2, 1);

    send(4'b1010, 1, 0, 0, 0);        // backpressure: second word overruns
    send(4'b0101, 1, 0, 0, 0);
    idle(2, 0);
    idle(2, 1);

    send(4'b0011, 1, 0, 0, 0);        // completion coincident with transfer
    send(4'b1100, 1, 0, 0, 1);
    idle(2, 1);

    step(1, 1, 1, 0, 0, 0, 1);        // clear mid-word
    step(1, 0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    send(4'b1001, 1, 0, 1, 1);
    idle(1, 1);
    step(1, 1, 1, 0, 0, 0, 1);        // reset mid-word
    step(1, 0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    send(4'b1001, 1, 0, 1, 1);
    idle(1, 1);
    step(1, 1, 0, 0, 1, 0, 1);        // no direction in IDLE: ignored
    step(1, 0, 0, 0, 1, 0, 1);
    idle(1, 1);

    for (int n = 0; n < 3000; n++) begin
      step(($urandom % 4) != 0, $urandom % 2, ($urandom % 3) == 0, ($urandom % 2) == 0,
           ($urandom % 2) == 0, ($urandom % 150) == 0, ($urandom % 400) != 0);
    end
    idle(4, 1);

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d words still expected, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
